// File: rtl/logIP_pkg.sv
// Shared constants and state encoding for the logIP host-link transmitter.
package logIP_pkg;

    // Default UART bit period in system clocks.
    localparam int UART_CLKS_PER_BIT = 20;

    // Sample word width and the number of 8-bit channel groups it holds.
    localparam int SAMPLE_W = 32;
    localparam int N_GROUPS = SAMPLE_W / 8;

    // 8N1 frame phases.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

endpackage

// File: rtl/sump_sample_tx_if.sv
// Sample-word handshake between the capture readout (master) and the
// transmit serializer (slave). A word moves on a cycle with stb && rdy.
interface sump_sample_tx_if #(
    parameter int WORD_W = logIP_pkg::SAMPLE_W
);

    logic [WORD_W-1:0]   data;  // byte k belongs to channel group k
    logic [WORD_W/8-1:0] mask;  // 1 = transmit that group's byte
    logic                stb;   // word valid
    logic                rdy;   // serializer can take a word

    modport master (output data, mask, stb, input rdy);
    modport slave  (input data, mask, stb, output rdy);

endinterface

// File: rtl/uart_tx8.sv
// Single-byte 8N1 transmitter. A byte offered with stb_i while rdy_o is high
// starts its start bit on the next cycle. rdy_o is also high during the last
// stop-bit cycle, so a caller can chain frames with no idle gap between them.
module uart_tx8
    import logIP_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT  // must be >= 2
) (
    input  logic       clk_i,
    input  logic       rst_in,
    input  logic [7:0] byte_i,
    input  logic       stb_i,
    output logic       rdy_o,
    output logic       tx_o,
    output logic       busy_o
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_e        state_q;
    logic [CNT_W-1:0] baud_q;
    logic [2:0]       bit_q;
    logic [7:0]       byte_q;
    logic             tx_q;
    logic             baud_wrap;

    assign baud_wrap = (baud_q == CNT_LAST);
    assign rdy_o     = (state_q == IDLE) || ((state_q == STOP) && baud_wrap);
    assign busy_o    = (state_q != IDLE);
    assign tx_o      = tx_q;

    // Frame sequencer: phase, baud and bit counters, and the registered line.
    // NOTE: non-blocking assignments so every branch reads pre-edge state;
    // blocking ones here would let a later line see an already-updated counter.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stb_i) begin
                        state_q <= START;
                        byte_q  <= byte_i;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        state_q <= DATA;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= byte_q[0];
                    end else begin
                        baud_q <= baud_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= byte_q[bit_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        baud_q <= '0;
                        // Chain straight into the next start bit when offered.
                        if (stb_i) begin
                            state_q <= START;
                            byte_q  <= byte_i;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sump_sample_tx.sv
// Sample-word serializer for the host link. Latches a sample word and its
// group mask, then sends each enabled byte (lowest group first) as a UART
// frame through uart_tx8, back to back. An all-zero mask drops the word.
module sump_sample_tx
    import logIP_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,  // must be >= 2
    parameter int WORD_W       = SAMPLE_W            // multiple of 8
) (
    input  logic             clk_i,
    input  logic             rst_in,
    sump_sample_tx_if.slave  smp,
    output logic             tx_o,
    output logic             busy_o
);

    localparam int                N_GRP = WORD_W / 8;
    localparam int                IDX_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam logic [N_GRP-1:0]  ONE_M = N_GRP'(1);

    // Index of the lowest set bit; only used when the mask is nonzero.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_GRP-1:0] m);
        lowest_set = '0;
        for (int k = N_GRP - 1; k >= 0; k--) begin
            if (m[k]) lowest_set = IDX_W'(k);
        end
    endfunction

    // Mask with its lowest set bit removed.
    function automatic logic [N_GRP-1:0] clear_lowest(input logic [N_GRP-1:0] m);
        clear_lowest = m & (m - ONE_M);
    endfunction

    logic [WORD_W-1:0]     data_q;   // latched sample word
    logic [N_GRP-1:0]      mask_q;   // groups still waiting to be sent
    logic                  rdy_q;

    logic                  accept;
    logic                  uart_rdy;
    logic                  uart_stb;
    logic [7:0]            uart_byte;
    logic [N_GRP-1:0]      src_mask;
    logic [N_GRP-1:0][7:0] src_lanes;
    logic [IDX_W-1:0]      byte_idx;

    assign accept  = smp.stb && rdy_q;
    assign smp.rdy = rdy_q;

    // Byte selection: on acceptance the lowest enabled lane of the incoming
    // word feeds the transmitter directly, afterwards the lowest pending lane.
    // NOTE: every output gets a value on every path, so no latch is inferred.
    always_comb begin
        src_mask  = rdy_q ? smp.mask : mask_q;
        src_lanes = rdy_q ? smp.data : data_q;
        byte_idx  = lowest_set(src_mask);
        uart_byte = src_lanes[byte_idx];
        uart_stb  = accept ? (|smp.mask) : (!rdy_q && uart_rdy && (|mask_q));
    end

    // Word latch and byte sequencing; rdy_q rises once the last frame's final
    // stop-bit cycle ends (or one cycle after a dropped all-zero word).
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            data_q <= '0;
            mask_q <= '0;
            rdy_q  <= 1'b1;
        end else if (accept) begin
            data_q <= smp.data;
            mask_q <= clear_lowest(smp.mask);
            rdy_q  <= 1'b0;
        end else if (!rdy_q && uart_rdy) begin
            if (|mask_q) begin
                mask_q <= clear_lowest(mask_q);
            end else begin
                rdy_q <= 1'b1;
            end
        end
    end

    uart_tx8 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx8 (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .byte_i (uart_byte),
        .stb_i  (uart_stb),
        .rdy_o  (uart_rdy),
        .tx_o   (tx_o),
        .busy_o (busy_o)
    );

endmodule

// File: tb/tb_sump_sample_tx.sv
// Directed bench for sump_sample_tx: a mid-bit-sampling Uart8 receiver model
// decodes tx_o into a byte queue; each scenario task compares it inline.
`timescale 1ns/1ps
module tb_sump_sample_tx;
    import logIP_pkg::*;

    localparam int CPB   = 20;
    localparam int FRAME = 10 * CPB;
    localparam int BOUND = 5000;

    logic clk    = 1'b0;
    logic rst_in = 1'b0;
    logic tx;
    logic busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    int         frame_err = 0;

    sump_sample_tx_if #(.WORD_W(32)) smp_if ();

    sump_sample_tx #(
        .CLKS_PER_BIT (CPB),
        .WORD_W       (32)
    ) dut (
        .clk_i  (clk),
        .rst_in (rst_in),
        .smp    (smp_if),
        .tx_o   (tx),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    // Uart8 receiver: detect the first low cycle, sample each bit mid-period.
    initial begin : uart8
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CPB) @(negedge clk);
                        b[i] = tx;
                    end
                    repeat (CPB) @(negedge clk);
                    if (tx !== 1'b1) frame_err++;
                    rx_q.push_back(b);
                end
            end
        end
    end

    // Count cycles (from the current one) that rdy stays low, and busy cycles among them.
    task automatic measure(output int rdy_low, output int busy_cyc);
        rdy_low  = 0;
        busy_cyc = 0;
        while (smp_if.rdy !== 1'b1 && rdy_low < BOUND) begin
            rdy_low++;
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int active;
        smp_if.stb  = 1'b0;
        smp_if.data = '0;
        smp_if.mask = '0;
        repeat (5) @(negedge clk);
        checks++; if (tx !== 1'b1)          begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (smp_if.rdy !== 1'b1)  begin failures++; $display("FAIL reset_rdy got=%b exp=1", smp_if.rdy); end
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_in = 1'b1;
        active = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || smp_if.rdy !== 1'b1) active++;
        end
        checks++; if (active != 0)      begin failures++; $display("FAIL reset_quiet active_cycles=%0d exp=0", active); end
        checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL reset_no_frame bytes=%0d exp=0", rx_q.size()); end
    endtask

    task automatic test_single_word;
        logic [7:0] exp [4];
        logic [7:0] got;
        int rdy_low, busy_cyc;
        exp = '{8'hF0, 8'h0F, 8'h5A, 8'hA5};
        rx_q.delete();
        frame_err = 0;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_pre_idle got=%b exp=1", tx); end
        smp_if.data = 32'hA55A_0FF0;
        smp_if.mask = 4'hF;
        smp_if.stb  = 1'b1;
        @(negedge clk);
        // Inputs may change right after acceptance.
        smp_if.stb  = 1'b0;
        smp_if.data = 32'hDEAD_BEEF;
        smp_if.mask = 4'h0;
        checks++; if (tx !== 1'b0)         begin failures++; $display("FAIL single_start_latency tx=%b exp=0", tx); end
        checks++; if (smp_if.rdy !== 1'b0) begin failures++; $display("FAIL single_rdy_drop got=%b exp=0", smp_if.rdy); end
        // A strobe while busy is ignored.
        repeat (30) @(negedge clk);
        smp_if.data = 32'hFFFF_FFFF;
        smp_if.mask = 4'hF;
        smp_if.stb  = 1'b1;
        @(negedge clk);
        smp_if.stb  = 1'b0;
        measure(rdy_low, busy_cyc);
        // Cycles 32..800 remain of the 800-cycle word.
        checks++; if (rdy_low != 4 * FRAME - 31)  begin failures++; $display("FAIL single_rdy_low got=%0d exp=%0d", rdy_low, 4 * FRAME - 31); end
        checks++; if (busy_cyc != 4 * FRAME - 31) begin failures++; $display("FAIL single_busy got=%0d exp=%0d", busy_cyc, 4 * FRAME - 31); end
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin failures++; $display("FAIL single_idle_after busy=%b tx=%b exp=0/1", busy, tx); end
        repeat (2) @(negedge clk);
        checks++; if (rx_q.size() != 4) begin failures++; $display("FAIL single_count got=%0d exp=4", rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, got, exp[i]); end
        end
        checks++; if (frame_err != 0) begin failures++; $display("FAIL single_framing errors=%0d exp=0", frame_err); end
    endtask

    task automatic test_masked_groups;
        logic [7:0] exp [2];
        logic [7:0] got;
        int rdy_low, busy_cyc;
        exp = '{8'h11, 8'h33};
        rx_q.delete();
        frame_err = 0;
        @(negedge clk);
        smp_if.data = 32'h4433_2211;
        smp_if.mask = 4'b0101;
        smp_if.stb  = 1'b1;
        @(negedge clk);
        smp_if.stb  = 1'b0;
        smp_if.mask = 4'hF;
        measure(rdy_low, busy_cyc);
        checks++; if (rdy_low != 2 * FRAME)  begin failures++; $display("FAIL masked_rdy_low got=%0d exp=%0d", rdy_low, 2 * FRAME); end
        checks++; if (busy_cyc != 2 * FRAME) begin failures++; $display("FAIL masked_busy got=%0d exp=%0d", busy_cyc, 2 * FRAME); end
        repeat (2) @(negedge clk);
        checks++; if (rx_q.size() != 2) begin failures++; $display("FAIL masked_count got=%0d exp=2", rx_q.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin failures++; $display("FAIL masked_byte%0d got=%h exp=%h", i, got, exp[i]); end
        end
    endtask

    task automatic test_zero_mask;
        int active;
        rx_q.delete();
        @(negedge clk);
        smp_if.data = 32'h1234_5678;
        smp_if.mask = 4'h0;
        smp_if.stb  = 1'b1;
        @(negedge clk);
        smp_if.stb = 1'b0;
        checks++; if (smp_if.rdy !== 1'b0)      begin failures++; $display("FAIL zero_rdy_drop got=%b exp=0", smp_if.rdy); end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_line tx=%b busy=%b exp=1/0", tx, busy); end
        @(negedge clk);
        checks++; if (smp_if.rdy !== 1'b1)      begin failures++; $display("FAIL zero_rdy_back got=%b exp=1", smp_if.rdy); end
        active = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) active++;
        end
        checks++; if (active != 0 || rx_q.size() != 0) begin failures++; $display("FAIL zero_quiet active=%0d bytes=%0d exp=0/0", active, rx_q.size()); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [2];
        logic [7:0] got;
        int n, rdy_low, busy_cyc;
        exp = '{8'hC3, 8'h3C};
        rx_q.delete();
        frame_err = 0;
        @(negedge clk);
        smp_if.data = 32'h0000_00C3;
        smp_if.mask = 4'h1;
        smp_if.stb  = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL bp_start tx=%b exp=0", tx); end
        repeat (50) @(negedge clk);
        smp_if.data = 32'h0000_003C;
        n = 0;
        while (smp_if.rdy !== 1'b1 && n < BOUND) begin
            n++;
            @(negedge clk);
        end
        // Now in cycle 201: rdy high and a single idle line cycle.
        checks++; if (n != FRAME - 50) begin failures++; $display("FAIL bp_rdy_rise got=%0d exp=%0d", n, FRAME - 50); end
        checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bp_idle_gap tx=%b busy=%b exp=1/0", tx, busy); end
        @(negedge clk);
        smp_if.stb = 1'b0;
        checks++; if (smp_if.rdy !== 1'b0 || tx !== 1'b0) begin failures++; $display("FAIL bp_second_accept rdy=%b tx=%b exp=0/0", smp_if.rdy, tx); end
        measure(rdy_low, busy_cyc);
        checks++; if (rdy_low != FRAME) begin failures++; $display("FAIL bp_second_len got=%0d exp=%0d", rdy_low, FRAME); end
        repeat (2) @(negedge clk);
        checks++; if (rx_q.size() != 2) begin failures++; $display("FAIL bp_count got=%0d exp=2", rx_q.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++; if (got !== exp[i]) begin failures++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got, exp[i]); end
        end
        checks++; if (frame_err != 0) begin failures++; $display("FAIL bp_framing errors=%0d exp=0", frame_err); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] got;
        int rdy_low, busy_cyc;
        @(negedge clk);
        smp_if.data = 32'h0000_0000;
        smp_if.mask = 4'h1;
        smp_if.stb  = 1'b1;
        @(negedge clk);
        smp_if.stb = 1'b0;
        // Cycle 110 lies inside data bit 4 (cycles 101..120).
        repeat (109) @(negedge clk);
        checks++; if (tx !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre tx=%b busy=%b exp=0/1", tx, busy); end
        rst_in = 1'b0;
        #1;
        checks++; if (tx !== 1'b1)         begin failures++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
        checks++; if (smp_if.rdy !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_rdy_busy rdy=%b busy=%b exp=1/0", smp_if.rdy, busy); end
        repeat (3) @(negedge clk);
        rst_in = 1'b1;
        repeat (300) @(negedge clk);
        rx_q.delete();
        frame_err = 0;
        smp_if.data = 32'h0000_0077;
        smp_if.mask = 4'h1;
        smp_if.stb  = 1'b1;
        @(negedge clk);
        smp_if.stb = 1'b0;
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL rstmid_restart tx=%b exp=0", tx); end
        measure(rdy_low, busy_cyc);
        checks++; if (rdy_low != FRAME) begin failures++; $display("FAIL rstmid_len got=%0d exp=%0d", rdy_low, FRAME); end
        repeat (2) @(negedge clk);
        got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        checks++; if (rx_q.size() != 1 || got !== 8'h77) begin failures++; $display("FAIL rstmid_byte got=%h count=%0d exp=77/1", got, rx_q.size()); end
        checks++; if (frame_err != 0) begin failures++; $display("FAIL rstmid_framing errors=%0d exp=0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_masked_groups();
        test_zero_mask();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
